// File: rtl/object_list_scanner_pkg.sv
// Shared definitions for the object list scanner: default field widths and FSM encoding.
package object_list_scanner_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int LOC_SIZE_DEF  = 11;
  localparam int OBJ_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_SEND,
    ST_FIN
  } scan_state_t;

  // A zero threshold would let empty (area 0) table entries through.
  function automatic int eff_min_area(input int min_area);
    return (min_area < 1) ? 1 : min_area;
  endfunction

endpackage

// File: rtl/object_list_scanner.sv
// Walks the labeler's object table for labels 1..num_labels-1, drops small objects
// and streams the survivors out over a valid/ready handshake, then pulses done.
module object_list_scanner
  import object_list_scanner_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int LOC_SIZE  = LOC_SIZE_DEF,
  parameter int OBJ_WIDTH = OBJ_WIDTH_DEF,
  parameter int RD_LAT    = 1,
  parameter int MIN_AREA  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic [WORD_SIZE-1:0] obj_id,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  input  logic [OBJ_WIDTH-1:0] obj_area,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_id,
  output logic [LOC_SIZE-1:0]  out_x,
  output logic [LOC_SIZE-1:0]  out_y,
  output logic [OBJ_WIDTH-1:0] out_area,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] obj_count
);

  localparam logic [OBJ_WIDTH-1:0] AREA_MIN  = OBJ_WIDTH'(eff_min_area(MIN_AREA));
  // ISSUE already covers one latency cycle, so WAIT is only entered for RD_LAT >= 2.
  localparam logic [1:0]           WAIT_LAST = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;
  localparam logic [WORD_SIZE-1:0] ID_ONE    = WORD_SIZE'(1);

  scan_state_t          state_reg;
  logic [WORD_SIZE-1:0] snap_reg;
  logic [1:0]           wait_cnt_reg;

  logic                 last_id;
  scan_state_t          adv_state;
  logic [WORD_SIZE-1:0] adv_id;

  // Shared "move to next label" decision used from CHECK (filtered) and SEND (accepted).
  always_comb begin
    last_id   = (obj_id == (snap_reg - ID_ONE));
    adv_state = last_id ? ST_FIN : ST_ISSUE;
    adv_id    = last_id ? obj_id : (obj_id + ID_ONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      snap_reg     <= '0;
      wait_cnt_reg <= '0;
      obj_id       <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      out_x        <= '0;
      out_y        <= '0;
      out_area     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      obj_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            snap_reg  <= num_labels;
            obj_count <= '0;
            busy      <= 1'b1;
            if (num_labels <= ID_ONE) begin
              state_reg <= ST_FIN;
            end else begin
              obj_id    <= ID_ONE;
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= (RD_LAT <= 1) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg <= ST_CHECK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end
        ST_CHECK: begin
          if (obj_area >= AREA_MIN) begin
            out_id    <= obj_id;
            out_x     <= obj_x;
            out_y     <= obj_y;
            out_area  <= obj_area;
            out_valid <= 1'b1;
            state_reg <= ST_SEND;
          end else begin
            obj_id    <= adv_id;
            state_reg <= adv_state;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            obj_count <= obj_count + ID_ONE;
            out_valid <= 1'b0;
            obj_id    <= adv_id;
            state_reg <= adv_state;
          end
        end
        ST_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          obj_id    <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
